spi_slave_reg_ctrl: RTL and testbench

//  Transaction sequencer on the byte interface of the SPI slave core. Turns each CS-framed byte stream into

---
 rtl/spi_slave_reg_ctrl.sv | 173 +++++++++++++++++
 tb/tb_spi_slave_reg_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_reg_ctrl.sv
// Purpose: turns CS-framed SPI byte streams into register-bus bursts (cmd byte {rw,addr}, then data).
// Latency: reg_wr/reg_rd strobe 1 clk after rx_valid; read data lands in tx_data 1 clk after reg_rd_valid.
// Backpressure: none; bytes must respect the prefetch window, rx_valid during a pending read sets err.
module spi_slave_reg_ctrl #(
    parameter int         RD_TIMEOUT = 8,
    parameter logic [3:0] STATUS_ID  = 4'hA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic [6:0] reg_addr,
    output logic       reg_wr,
    output logic [7:0] reg_wdata,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    input  logic       reg_rd_valid,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_WAIT = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    localparam int            CW       = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);
    localparam logic [7:0]    RD_FAIL  = 8'hEE;

    state_t        state_q, state_d;
    logic [6:0]    addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tx_q, tx_d;
    logic          err_q, err_d;
    logic [6:0]    reg_addr_q, reg_addr_d;
    logic [7:0]    reg_wdata_q, reg_wdata_d;
    logic          reg_wr_q, reg_wr_d;
    logic          reg_rd_q, reg_rd_d;

    // cs_n is raw and asynchronous; idle level is high, so the chain resets high
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic cs_rise;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            cs_meta_q <= cs_n;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
        end
    end

    assign cs_rise = cs_sync_q & ~cs_prev_q;

    // Next-state and strobe generation; a CS release is applied last so the current byte is still honoured
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        err_d       = err_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    // Command byte: tx_data holds the status the core already latched for byte1
                    err_d  = 1'b0;
                    addr_d = rx_data[6:0];
                    if (rx_data[7]) begin
                        reg_rd_d   = 1'b1;
                        reg_addr_d = rx_data[6:0];
                        cnt_d      = '0;
                        state_d    = RD_WAIT;
                    end else begin
                        state_d = WR_DATA;
                    end
                end else begin
                    tx_d = {STATUS_ID, 2'b00, err_q, 1'b1};
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    reg_wr_d    = 1'b1;
                    reg_addr_d  = addr_q;
                    reg_wdata_d = rx_data;
                    addr_d      = addr_q + 7'd1;
                end
            end
            RD_WAIT: begin
                // A byte arriving before the prefetch completes is a host timing violation
                if (rx_valid) begin
                    err_d = 1'b1;
                end
                if (reg_rd_valid) begin
                    tx_d    = reg_rdata;
                    state_d = RD_DATA;
                end else if (cnt_q == CNT_LAST) begin
                    tx_d    = RD_FAIL;
                    err_d   = 1'b1;
                    state_d = RD_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_DATA: begin
                if (rx_valid) begin
                    addr_d     = addr_q + 7'd1;
                    reg_rd_d   = 1'b1;
                    reg_addr_d = addr_q + 7'd1;
                    cnt_d      = '0;
                    state_d    = RD_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cs_rise) begin
            state_d  = IDLE;
            reg_rd_d = 1'b0;
            cnt_d    = '0;
            tx_d     = {STATUS_ID, 2'b00, err_d, 1'b1};
        end
    end

    // State, counters and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            tx_q        <= {STATUS_ID, 2'b00, 1'b0, 1'b1};
            err_q       <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            err_q       <= err_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
        end
    end

    assign tx_data   = tx_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Purpose: directed bench for spi_slave_reg_ctrl with a small register-bank model and bus logs.
// Latency: bank answers reads 3 clk after reg_rd; bytes spaced GAP clk apart like a slow SPI link.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_spi_slave_reg_ctrl;

    localparam int GAP = 10;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       reg_rd_valid;
    logic       busy;
    logic       err;

    spi_slave_reg_ctrl #(.RD_TIMEOUT(8), .STATUS_ID(4'hA)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_n         (cs_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .reg_addr     (reg_addr),
        .reg_wr       (reg_wr),
        .reg_wdata    (reg_wdata),
        .reg_rd       (reg_rd),
        .reg_rdata    (reg_rdata),
        .reg_rd_valid (reg_rd_valid),
        .busy         (busy),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register bank model: reg[x] = x+1, answered 3 cycles after reg_rd when enabled
    logic       bank_en;
    logic       man_vld;
    logic [2:0] rd_sh;
    logic [6:0] a_sh0, a_sh1, a_sh2;

    initial begin
        rd_sh = '0;
        a_sh0 = '0;
        a_sh1 = '0;
        a_sh2 = '0;
    end

    always @(negedge clk) begin
        rd_sh <= {rd_sh[1:0], reg_rd & bank_en};
        a_sh0 <= reg_addr;
        a_sh1 <= a_sh0;
        a_sh2 <= a_sh1;
    end

    assign reg_rd_valid = rd_sh[2] | man_vld;
    assign reg_rdata    = man_vld ? 8'h5A : ({1'b0, a_sh2} + 8'd1);

    // Bus activity logs, sampled mid-cycle
    logic [14:0] wr_log[$];
    logic [6:0]  rd_log[$];

    always @(negedge clk) begin
        if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
        if (reg_rd) rd_log.push_back(reg_addr);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        return (wr_log.size() > i) ? {17'd0, wr_log[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        return (rd_log.size() > i) ? {25'd0, rd_log[i]} : 32'hDEAD_BEEF;
    endfunction

    // One SPI byte: MISO is what the core loads at byte start, then rx_valid pulses after the shift time
    task automatic xfer(input logic [7:0] b, output logic [7:0] miso);
        @(negedge clk);
        miso = tx_data;
        repeat (GAP) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
    endtask

    logic [7:0] m0, m1, m2, m3, m4;
    int         cyc;

    initial begin
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        bank_en  = 1'b0;
        man_vld  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx", tx_data, 8'hA1);
        chk("rst_addr", reg_addr, 7'h00);
        chk("rst_wdata", reg_wdata, 8'h00);
        chk("rst_wr_rd", {reg_wr, reg_rd}, 2'b00);
        chk("rst_busy_err", {busy, err}, 2'b00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: write burst
        clear_logs();
        cs_low();
        xfer(8'h10, m0);
        chk("t1_busy", busy, 1'b1);
        xfer(8'h55, m1);
        xfer(8'hAA, m2);
        cs_high();
        chk("t1_busy_drop", busy, 1'b0);
        chk("t1_nwr", wr_log.size(), 2);
        chk("t1_wr0", wr_at(0), {17'd0, 7'h10, 8'h55});
        chk("t1_wr1", wr_at(1), {17'd0, 7'h11, 8'hAA});

        // 2: read burst with latency-3 bank
        clear_logs();
        bank_en = 1'b1;
        cs_low();
        xfer(8'h90, m0);
        xfer(8'h00, m1);
        xfer(8'h00, m2);
        xfer(8'h00, m3);
        xfer(8'h00, m4);
        chk("t2_miso0", m0, 8'hA1);
        chk("t2_miso1", m1, 8'hA1);
        chk("t2_miso2", m2, 8'h11);
        chk("t2_miso3", m3, 8'h12);
        chk("t2_miso4", m4, 8'h13);
        cs_high();
        chk("t2_rd0", rd_at(0), 32'h10);
        chk("t2_rd2", rd_at(2), 32'h12);
        chk("t2_nwr", wr_log.size(), 0);
        chk("t2_err", err, 1'b0);

        // 3: address wrap for writes and reads
        clear_logs();
        cs_low();
        xfer(8'h7F, m0);
        xfer(8'h01, m1);
        xfer(8'h02, m2);
        cs_high();
        chk("t3_wr0", wr_at(0), {17'd0, 7'h7F, 8'h01});
        chk("t3_wr1", wr_at(1), {17'd0, 7'h00, 8'h02});
        cs_low();
        xfer(8'hFF, m0);
        xfer(8'h00, m1);
        xfer(8'h00, m2);
        chk("t3_rmiso2", m2, 8'h80);
        cs_high();
        chk("t3_rd0", rd_at(0), 32'h7F);
        chk("t3_rd1", rd_at(1), 32'h00);
        bank_en = 1'b0;
        repeat (4) @(negedge clk);

        // 4: read timeout
        clear_logs();
        cs_low();
        xfer(8'h85, m0);
        cyc = 0;
        while (tx_data !== 8'hEE && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_cycles", cyc, 8);
        chk("t4_err", err, 1'b1);
        chk("t4_rd", rd_at(0), 32'h05);
        cs_high();
        chk("t4_idle_tx", tx_data, 8'hA3);
        cs_low();
        xfer(8'h20, m0);
        chk("t4_next_miso0", m0, 8'hA3);
        chk("t4_err_clr", err, 1'b0);
        cs_high();

        // 5a: abort while a read is pending, late completion is ignored
        clear_logs();
        cs_low();
        xfer(8'h83, m0);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_busy", busy, 1'b0);
        man_vld = 1'b1;
        @(negedge clk);
        man_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_tx", tx_data, 8'hA1);
        chk("t5_busy2", busy, 1'b0);
        chk("t5_nrd", rd_log.size(), 1);
        repeat (10) @(negedge clk);
        chk("t5_nrd_late", rd_log.size(), 1);

        // 5b: CS release lands on the same cycle as the last data byte
        clear_logs();
        cs_low();
        xfer(8'h30, m0);
        xfer(8'hB1, m1);
        repeat (GAP) @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_data  = 8'hC3;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5b_nwr", wr_log.size(), 2);
        chk("t5b_wr1", wr_at(1), {17'd0, 7'h31, 8'hC3});
        chk("t5b_busy", busy, 1'b0);

        // 6: reset mid-burst, then a fresh command
        clear_logs();
        cs_low();
        xfer(8'h40, m0);
        xfer(8'h11, m1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_tx", tx_data, 8'hA1);
        chk("t6_addr", reg_addr, 7'h00);
        chk("t6_wdata", reg_wdata, 8'h00);
        chk("t6_flags", {reg_wr, reg_rd, busy, err}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        xfer(8'h50, m0);
        xfer(8'h77, m1);
        cs_high();
        chk("t6_nwr", wr_log.size(), 1);
        chk("t6_wr0", wr_at(0), {17'd0, 7'h50, 8'h77});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
